bus_dma: RTL

Single-channel word-copy DMA engine for the Ibex super system bus. It is a bus device: the core programs source, destination and length through a four-register window. It is also a bus host: it moves the data with its own req/gnt/rvalid transactions, one word at a time. It occupies one device slot and one extra host slot on the system `bus`, and raises a level interrupt on completion (intended for a spare `irq_fast_i` line).

---
 rtl/bus_dma.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/bus_dma.sv
// Single-channel word-copy DMA: a four-register bus device that moves data as a
// bus host, one read then one write per word, with a level completion interrupt.
module bus_dma #(
    parameter int unsigned LenWidth = 16
) (
    input  logic        clk_sys_i,
    input  logic        rst_sys_ni,
    input  logic        dev_req_i,
    input  logic [31:0] dev_addr_i,
    input  logic        dev_we_i,
    input  logic [3:0]  dev_be_i,
    input  logic [31:0] dev_wdata_i,
    output logic        dev_rvalid_o,
    output logic [31:0] dev_rdata_o,
    output logic        dev_err_o,
    output logic        host_req_o,
    input  logic        host_gnt_i,
    output logic [31:0] host_addr_o,
    output logic        host_we_o,
    output logic [3:0]  host_be_o,
    output logic [31:0] host_wdata_o,
    input  logic        host_rvalid_i,
    input  logic [31:0] host_rdata_i,
    input  logic        host_err_i,
    output logic        irq_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_REQ,
        S_RD_WAIT,
        S_WR_REQ,
        S_WR_WAIT
    } state_e;

    state_e r_state;
    state_e w_state_next;

    logic [31:0]         r_src;
    logic [31:0]         r_dst;
    logic [LenWidth-1:0] r_len;
    logic [31:0]         r_src_cur;
    logic [31:0]         r_dst_cur;
    logic [LenWidth-1:0] r_remaining;
    logic [31:0]         r_buf;
    logic                r_ien;
    logic                r_done;
    logic                r_err;
    logic                r_dev_rvalid;
    logic [31:0]         r_dev_rdata;

    logic        w_busy;
    logic        w_reg_wr;
    logic [1:0]  w_sel;
    logic        w_ctrl_wr;
    logic        w_start;
    logic        w_len_zero;
    logic        w_last;
    logic        w_rd_ok;
    logic        w_wr_ok;
    logic        w_xfer_err;
    logic        w_done_set;
    logic        w_done_clr;
    logic [31:0] w_rd_mux;
    logic        w_unused;

    assign w_busy     = (r_state != S_IDLE);
    assign w_reg_wr   = dev_req_i & dev_we_i;
    assign w_sel      = dev_addr_i[3:2];
    assign w_ctrl_wr  = w_reg_wr & (w_sel == 2'd3);
    assign w_start    = w_ctrl_wr & dev_wdata_i[0] & ~w_busy;
    assign w_len_zero = (r_len == '0);
    assign w_last     = (r_remaining == LenWidth'(1));
    assign w_rd_ok    = (r_state == S_RD_WAIT) & host_rvalid_i & ~host_err_i;
    assign w_wr_ok    = (r_state == S_WR_WAIT) & host_rvalid_i & ~host_err_i;
    assign w_xfer_err = ((r_state == S_RD_WAIT) | (r_state == S_WR_WAIT)) &
                        host_rvalid_i & host_err_i;

    // A set event in the same cycle as a clear keeps DONE high.
    assign w_done_set = w_xfer_err | (w_wr_ok & w_last) | (w_start & w_len_zero);
    assign w_done_clr = (w_ctrl_wr & dev_wdata_i[2]) | w_start;

    assign irq_o     = r_done & r_ien;
    assign dev_err_o = 1'b0;
    assign dev_rvalid_o = r_dev_rvalid;
    assign dev_rdata_o  = r_dev_rdata;
    assign w_unused  = ^{dev_be_i, dev_addr_i[31:4], dev_addr_i[1:0]};

    always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
        if (!rst_sys_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:    if (w_start && !w_len_zero) w_state_next = S_RD_REQ;
            S_RD_REQ:  if (host_gnt_i) w_state_next = S_RD_WAIT;
            S_RD_WAIT: if (host_rvalid_i) w_state_next = host_err_i ? S_IDLE : S_WR_REQ;
            S_WR_REQ:  if (host_gnt_i) w_state_next = S_WR_WAIT;
            S_WR_WAIT: if (host_rvalid_i) begin
                w_state_next = (host_err_i || w_last) ? S_IDLE : S_RD_REQ;
            end
            default:   w_state_next = S_IDLE;
        endcase
    end

    // Host outputs are decoded from state so a reset silences the bus at once.
    always_comb begin
        host_req_o   = 1'b0;
        host_we_o    = 1'b0;
        host_be_o    = 4'h0;
        host_addr_o  = 32'h0;
        host_wdata_o = 32'h0;
        case (r_state)
            S_RD_REQ: begin
                host_req_o  = 1'b1;
                host_be_o   = 4'hF;
                host_addr_o = r_src_cur;
            end
            S_WR_REQ: begin
                host_req_o   = 1'b1;
                host_we_o    = 1'b1;
                host_be_o    = 4'hF;
                host_addr_o  = r_dst_cur;
                host_wdata_o = r_buf;
            end
            default: ;
        endcase
    end

    always_comb begin
        w_rd_mux = 32'h0;
        case (w_sel)
            2'd0: w_rd_mux = r_src;
            2'd1: w_rd_mux = r_dst;
            2'd2: w_rd_mux = 32'(r_len);
            2'd3: w_rd_mux = {28'h0, r_err, r_done, r_ien, w_busy};
            default: w_rd_mux = 32'h0;
        endcase
    end

    always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
        if (!rst_sys_ni) begin
            r_src        <= 32'h0;
            r_dst        <= 32'h0;
            r_len        <= '0;
            r_src_cur    <= 32'h0;
            r_dst_cur    <= 32'h0;
            r_remaining  <= '0;
            r_buf        <= 32'h0;
            r_ien        <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_dev_rvalid <= 1'b0;
            r_dev_rdata  <= 32'h0;
        end else begin
            if (w_reg_wr && !w_busy) begin
                case (w_sel)
                    2'd0: r_src <= {dev_wdata_i[31:2], 2'b00};
                    2'd1: r_dst <= {dev_wdata_i[31:2], 2'b00};
                    2'd2: r_len <= dev_wdata_i[LenWidth-1:0];
                    default: ;
                endcase
            end
            if (w_ctrl_wr) begin
                r_ien <= dev_wdata_i[1];
            end

            if (w_start) begin
                r_src_cur   <= r_src;
                r_dst_cur   <= r_dst;
                r_remaining <= r_len;
            end else if (w_wr_ok) begin
                r_src_cur   <= r_src_cur + 32'd4;
                r_dst_cur   <= r_dst_cur + 32'd4;
                r_remaining <= r_remaining - LenWidth'(1);
            end

            if (w_rd_ok) begin
                r_buf <= host_rdata_i;
            end

            if (w_done_set) begin
                r_done <= 1'b1;
            end else if (w_done_clr) begin
                r_done <= 1'b0;
            end

            if (w_xfer_err) begin
                r_err <= 1'b1;
            end else if (w_start) begin
                r_err <= 1'b0;
            end

            // Snapshot is taken before this cycle's write lands.
            r_dev_rvalid <= dev_req_i;
            r_dev_rdata  <= (dev_req_i && !dev_we_i) ? w_rd_mux : 32'h0;
        end
    end

endmodule
